// File: rtl/tausworth_urgn_mc.sv
// Multi-channel three-component Tausworthe (taus88) uniform generator with a one-entry valid/ready output register.
// Optional seed validation is enabled by defining URGN_SEED_CHECK_EN.
module tausworth_urgn_lane #(
  parameter logic [31:0] P0 = 32'hFFFFFFFF,
  parameter logic [31:0] P1 = 32'hCCCCCCCD,
  parameter logic [31:0] P2 = 32'h00FF00FF,
  parameter int          K  = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        adv,
  input  logic        wr,
  input  logic [1:0]  sel,
  input  logic [31:0] data,
  output logic [31:0] word
);
  // Golden-ratio stride decorrelates the per-channel reset seeds.
  localparam logic [31:0] KMUL = 32'(K) * 32'h9E3779B9;

  logic [31:0] s0, s1, s2;
  logic [31:0] b0, b1, b2;

  assign b0   = ((s0 << 13) ^ s0) >> 19;
  assign b1   = ((s1 << 2)  ^ s1) >> 25;
  assign b2   = ((s2 << 3)  ^ s2) >> 11;
  assign word = s0 ^ s1 ^ s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      s0 <= (P0 ^ KMUL) | 32'h2;
      s1 <= (P1 ^ KMUL) | 32'h8;
      s2 <= (P2 ^ KMUL) | 32'h10;
    end else if (wr) begin
      case (sel)
        2'd0:    s0 <= data;
        2'd1:    s1 <= data;
        2'd2:    s2 <= data;
        default: ;
      endcase
    end else if (adv) begin
      s0 <= ((s0 & 32'hFFFFFFFE) << 12) ^ b0;
      s1 <= ((s1 & 32'hFFFFFFF8) << 4)  ^ b1;
      s2 <= ((s2 & 32'hFFFFFFF0) << 17) ^ b2;
    end
  end
endmodule

module tausworth_urgn_mc #(
  parameter int          NCH   = 4,
  parameter int          OUT_W = 32,
  parameter logic [31:0] P0    = 32'hFFFFFFFF,
  parameter logic [31:0] P1    = 32'hCCCCCCCD,
  parameter logic [31:0] P2    = 32'h00FF00FF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NCH*OUT_W-1:0] out_data,
  input  logic                 seed_wr,
  input  logic [3:0]           seed_ch,
  input  logic [1:0]           seed_sel,
  input  logic [31:0]          seed_data,
  output logic                 seed_err,
  output logic [31:0]          sample_cnt
);
  logic                        load, accept, addr_ok, bad, wr_ok;
  logic [NCH-1:0][31:0]        word;
  logic [NCH-1:0][OUT_W-1:0]   nxt;

  // A seed write stalls the whole generator for that cycle.
  assign load    = enable && !seed_wr && (!out_valid || out_ready);
  assign accept  = out_valid && out_ready;
  assign addr_ok = seed_wr && (32'(seed_ch) < NCH) && (seed_sel != 2'd3);

`ifdef URGN_SEED_CHECK_EN
  // Values below these bounds collapse the component into a degenerate cycle.
  assign bad = (seed_sel == 2'd0 && seed_data <= 32'd1) ||
               (seed_sel == 2'd1 && seed_data <= 32'd7) ||
               (seed_sel == 2'd2 && seed_data <= 32'd15);

  always_ff @(posedge clk) begin
    if (reset) seed_err <= 1'b0;
    else       seed_err <= addr_ok && bad;
  end
`else
  assign bad      = 1'b0;
  assign seed_err = 1'b0;
`endif

  assign wr_ok = addr_ok && !bad;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    tausworth_urgn_lane #(.P0(P0), .P1(P1), .P2(P2), .K(g)) u_lane (
      .clk   (clk),
      .reset (reset),
      .adv   (load),
      .wr    (wr_ok && seed_ch == 4'(g)),
      .sel   (seed_sel),
      .data  (seed_data),
      .word  (word[g])
    );
    assign nxt[g] = word[g][31 -: OUT_W];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      sample_cnt <= '0;
    end else begin
      if (load) begin
        out_data  <= nxt;
        out_valid <= 1'b1;
      end else if (accept) begin
        out_valid <= 1'b0;
      end
      if (accept) sample_cnt <= sample_cnt + 32'd1;
    end
  end
endmodule
